// File: rtl/write_back_data_cache.sv
// Two-way set-associative write-back data cache with one-word lines,
// true-LRU replacement per set and a full-cache flush engine.

`ifndef ONE_BYTE
`define ONE_BYTE          3'b001
`define TWO_BYTE          3'b010
`define FOUR_BYTE         3'b100
`endif
`ifndef D_CACHE_NOP
`define D_CACHE_NOP       2'b00
`define D_CACHE_LOAD      2'b01
`define D_CACHE_STORE     2'b10
`endif
`ifndef D_CACHE_RESTING
`define D_CACHE_RESTING   2'b00
`define D_CACHE_WORKING   2'b01
`define D_CACHE_STALL     2'b10
`define L_S_FINISHED      2'b11
`endif
`ifndef MEM_NOP
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`endif
`ifndef MEM_DATA_FINISHED
`define MEM_DATA_FINISHED 2'b01
`endif

module write_back_data_cache #(
  parameter int ADDR_WIDTH     = 17,
  parameter int LEN            = 32,
  parameter int SET_INDEX_SIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [2:0]            data_type,
  input  logic [LEN-1:0]        cache_written_data,
  input  logic [1:0]            cache_vis_signal,
  input  logic                  flush_req,
  output logic                  cache_hit,
  output logic [LEN-1:0]        data,
  output logic [1:0]            d_cache_vis_status,
  output logic                  misaligned,
  output logic                  flush_done,
  input  logic [LEN-1:0]        mem_data,
  input  logic [1:0]            mem_status,
  output logic [1:0]            mem_vis_signal,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [LEN-1:0]        mem_written_data
);

  localparam int SETS  = 1 << SET_INDEX_SIZE;
  localparam int TAG_W = ADDR_WIDTH - SET_INDEX_SIZE - 2;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITEBACK  = 3'd1,
    S_FILL       = 3'd2,
    S_FLUSH_SCAN = 3'd3,
    S_FLUSH_WB   = 3'd4
  } state_e;

  // Byte-lane mask for an access size, right-aligned.
  function automatic logic [LEN-1:0] size_mask(input logic [2:0] t);
    case (t)
      `ONE_BYTE: size_mask = {{(LEN-8){1'b0}}, 8'hFF};
      `TWO_BYTE: size_mask = {{(LEN-16){1'b0}}, 16'hFFFF};
      default:   size_mask = {LEN{1'b1}};
    endcase
  endfunction

  // Zero-extended little-endian read of the addressed lanes.
  function automatic logic [LEN-1:0] load_extract(input logic [LEN-1:0] line,
                                                  input logic [1:0] off,
                                                  input logic [2:0] t);
    load_extract = (line >> {off, 3'b000}) & size_mask(t);
  endfunction

  // Merge right-aligned store data into the addressed lanes of a line.
  function automatic logic [LEN-1:0] store_merge(input logic [LEN-1:0] line,
                                                 input logic [LEN-1:0] wdata,
                                                 input logic [1:0] off,
                                                 input logic [2:0] t);
    logic [LEN-1:0] mask;
    mask        = size_mask(t) << {off, 3'b000};
    store_merge = (line & ~mask) | ((wdata & size_mask(t)) << {off, 3'b000});
  endfunction

  // Natural-alignment check; byte accesses are always aligned.
  function automatic logic is_misaligned(input logic [1:0] lo, input logic [2:0] t);
    case (t)
      `TWO_BYTE:  is_misaligned = lo[0];
      `FOUR_BYTE: is_misaligned = (lo != 2'b00);
      default:    is_misaligned = 1'b0;
    endcase
  endfunction

  state_e state_q, state_d;
  logic [SETS-1:0][1:0]            valid_q, valid_d;
  logic [SETS-1:0][1:0]            dirty_q, dirty_d;
  logic [SETS-1:0][1:0][TAG_W-1:0] tag_q, tag_d;
  logic [SETS-1:0][1:0][LEN-1:0]   line_q, line_d;
  logic [SETS-1:0]                 lru_q, lru_d;

  logic [ADDR_WIDTH-1:0]     req_addr_q, req_addr_d;
  logic [2:0]                req_type_q, req_type_d;
  logic [LEN-1:0]            req_wdata_q, req_wdata_d;
  logic                      req_store_q, req_store_d;
  logic                      victim_q, victim_d;
  logic [SET_INDEX_SIZE-1:0] flush_set_q, flush_set_d;
  logic                      flush_way_q, flush_way_d;

  logic [LEN-1:0]        data_q, data_d;
  logic [1:0]            status_q, status_d;
  logic [1:0]            mem_sig_q, mem_sig_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LEN-1:0]        mem_wdata_q, mem_wdata_d;
  logic                  misaligned_q, misaligned_d;
  logic                  flush_done_q, flush_done_d;

  logic [SET_INDEX_SIZE-1:0] req_idx_s, r_idx_s;
  logic [TAG_W-1:0]          req_tag_s, r_tag_s;
  logic                      req_valid_s, hit0_s, hit1_s, hit_s, hit_way_s;
  logic                      mem_done_s, flush_last_s, victim_s;

  // Decode the live request and look it up in both ways of its set.
  always_comb begin
    req_idx_s    = data_addr[SET_INDEX_SIZE+1:2];
    req_tag_s    = data_addr[ADDR_WIDTH-1:SET_INDEX_SIZE+2];
    r_idx_s      = req_addr_q[SET_INDEX_SIZE+1:2];
    r_tag_s      = req_addr_q[ADDR_WIDTH-1:SET_INDEX_SIZE+2];
    req_valid_s  = (cache_vis_signal == `D_CACHE_LOAD) || (cache_vis_signal == `D_CACHE_STORE);
    hit0_s       = valid_q[req_idx_s][0] && (tag_q[req_idx_s][0] == req_tag_s);
    hit1_s       = valid_q[req_idx_s][1] && (tag_q[req_idx_s][1] == req_tag_s);
    hit_s        = hit0_s || hit1_s;
    hit_way_s    = !hit0_s;
    mem_done_s   = (mem_status == `MEM_DATA_FINISHED);
    flush_last_s = flush_way_q && (&flush_set_q);
    if (!valid_q[req_idx_s][0]) begin
      victim_s = 1'b0;
    end else if (!valid_q[req_idx_s][1]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_q[req_idx_s];
    end
    cache_hit = (state_q == S_IDLE) && req_valid_s && hit_s;
  end

  // Next-state, array update and registered-output computation.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    line_d       = line_q;
    lru_d        = lru_q;
    req_addr_d   = req_addr_q;
    req_type_d   = req_type_q;
    req_wdata_d  = req_wdata_q;
    req_store_d  = req_store_q;
    victim_d     = victim_q;
    flush_set_d  = flush_set_q;
    flush_way_d  = flush_way_q;
    data_d       = data_q;
    status_d     = status_q;
    mem_sig_d    = mem_sig_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    misaligned_d = 1'b0;
    flush_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        status_d  = `D_CACHE_RESTING;
        mem_sig_d = `MEM_NOP;
        if (flush_req) begin
          // Flush wins; a simultaneous request must be presented again.
          state_d     = S_FLUSH_SCAN;
          flush_set_d = {SET_INDEX_SIZE{1'b0}};
          flush_way_d = 1'b0;
          status_d    = `D_CACHE_WORKING;
        end else if (req_valid_s) begin
          if (is_misaligned(data_addr[1:0], data_type)) begin
            misaligned_d = 1'b1;
            status_d     = `L_S_FINISHED;
          end else if (hit_s) begin
            lru_d[req_idx_s] = !hit_way_s;
            status_d         = `L_S_FINISHED;
            if (cache_vis_signal == `D_CACHE_STORE) begin
              line_d[req_idx_s][hit_way_s]  = store_merge(line_q[req_idx_s][hit_way_s],
                                                          cache_written_data, data_addr[1:0], data_type);
              dirty_d[req_idx_s][hit_way_s] = 1'b1;
            end else begin
              data_d = load_extract(line_q[req_idx_s][hit_way_s], data_addr[1:0], data_type);
            end
          end else begin
            req_addr_d  = data_addr;
            req_type_d  = data_type;
            req_wdata_d = cache_written_data;
            req_store_d = (cache_vis_signal == `D_CACHE_STORE);
            victim_d    = victim_s;
            status_d    = `D_CACHE_WORKING;
            if (valid_q[req_idx_s][victim_s] && dirty_q[req_idx_s][victim_s]) begin
              state_d     = S_WRITEBACK;
              mem_sig_d   = `MEM_WRITE;
              mem_addr_d  = {tag_q[req_idx_s][victim_s], req_idx_s, 2'b00};
              mem_wdata_d = line_q[req_idx_s][victim_s];
            end else begin
              state_d    = S_FILL;
              mem_sig_d  = `MEM_READ;
              mem_addr_d = {data_addr[ADDR_WIDTH-1:2], 2'b00};
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WRITEBACK: begin
        status_d = `D_CACHE_STALL;
        if (mem_done_s) begin
          state_d    = S_FILL;
          mem_sig_d  = `MEM_READ;
          mem_addr_d = {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_FILL: begin
        status_d = `D_CACHE_STALL;
        if (mem_done_s) begin
          valid_d[r_idx_s][victim_q] = 1'b1;
          tag_d[r_idx_s][victim_q]   = r_tag_s;
          lru_d[r_idx_s]             = !victim_q;
          if (req_store_q) begin
            line_d[r_idx_s][victim_q]  = store_merge(mem_data, req_wdata_q, req_addr_q[1:0], req_type_q);
            dirty_d[r_idx_s][victim_q] = 1'b1;
          end else begin
            line_d[r_idx_s][victim_q]  = mem_data;
            dirty_d[r_idx_s][victim_q] = 1'b0;
            data_d = load_extract(mem_data, req_addr_q[1:0], req_type_q);
          end
          status_d  = `L_S_FINISHED;
          mem_sig_d = `MEM_NOP;
          state_d   = S_IDLE;
        end else begin
          state_d = S_FILL;
        end
      end

      S_FLUSH_SCAN: begin
        status_d = `D_CACHE_WORKING;
        if (valid_q[flush_set_q][flush_way_q] && dirty_q[flush_set_q][flush_way_q]) begin
          state_d     = S_FLUSH_WB;
          status_d    = `D_CACHE_STALL;
          mem_sig_d   = `MEM_WRITE;
          mem_addr_d  = {tag_q[flush_set_q][flush_way_q], flush_set_q, 2'b00};
          mem_wdata_d = line_q[flush_set_q][flush_way_q];
        end else if (flush_last_s) begin
          state_d      = S_IDLE;
          status_d     = `D_CACHE_RESTING;
          flush_done_d = 1'b1;
        end else begin
          flush_way_d = !flush_way_q;
          flush_set_d = flush_way_q ? flush_set_q + 1'b1 : flush_set_q;
        end
      end

      S_FLUSH_WB: begin
        status_d = `D_CACHE_STALL;
        if (mem_done_s) begin
          dirty_d[flush_set_q][flush_way_q] = 1'b0;
          mem_sig_d = `MEM_NOP;
          if (flush_last_s) begin
            state_d      = S_IDLE;
            status_d     = `D_CACHE_RESTING;
            flush_done_d = 1'b1;
          end else begin
            state_d     = S_FLUSH_SCAN;
            status_d    = `D_CACHE_WORKING;
            flush_way_d = !flush_way_q;
            flush_set_d = flush_way_q ? flush_set_q + 1'b1 : flush_set_q;
          end
        end else begin
          state_d = S_FLUSH_WB;
        end
      end

      default: begin
        state_d   = S_IDLE;
        status_d  = `D_CACHE_RESTING;
        mem_sig_d = `MEM_NOP;
      end
    endcase
  end

  // State, storage and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      tag_q        <= '0;
      line_q       <= '0;
      lru_q        <= '0;
      req_addr_q   <= '0;
      req_type_q   <= 3'b000;
      req_wdata_q  <= '0;
      req_store_q  <= 1'b0;
      victim_q     <= 1'b0;
      flush_set_q  <= '0;
      flush_way_q  <= 1'b0;
      data_q       <= '0;
      status_q     <= `D_CACHE_RESTING;
      mem_sig_q    <= `MEM_NOP;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      misaligned_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      lru_q        <= lru_d;
      req_addr_q   <= req_addr_d;
      req_type_q   <= req_type_d;
      req_wdata_q  <= req_wdata_d;
      req_store_q  <= req_store_d;
      victim_q     <= victim_d;
      flush_set_q  <= flush_set_d;
      flush_way_q  <= flush_way_d;
      data_q       <= data_d;
      status_q     <= status_d;
      mem_sig_q    <= mem_sig_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      misaligned_q <= misaligned_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign data               = data_q;
  assign d_cache_vis_status = status_q;
  assign mem_vis_signal     = mem_sig_q;
  assign mem_vis_addr       = mem_addr_q;
  assign mem_written_data   = mem_wdata_q;
  assign misaligned         = misaligned_q;
  assign flush_done         = flush_done_q;

endmodule

// File: tb/tb_write_back_data_cache.sv
// Directed bench for write_back_data_cache with a fixed-latency memory responder.

`ifndef ONE_BYTE
`define ONE_BYTE          3'b001
`define TWO_BYTE          3'b010
`define FOUR_BYTE         3'b100
`endif
`ifndef D_CACHE_NOP
`define D_CACHE_NOP       2'b00
`define D_CACHE_LOAD      2'b01
`define D_CACHE_STORE     2'b10
`endif
`ifndef D_CACHE_RESTING
`define D_CACHE_RESTING   2'b00
`define D_CACHE_WORKING   2'b01
`define D_CACHE_STALL     2'b10
`define L_S_FINISHED      2'b11
`endif
`ifndef MEM_NOP
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`endif
`ifndef MEM_DATA_FINISHED
`define MEM_DATA_FINISHED 2'b01
`endif

module tb_write_back_data_cache;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] data_addr;
  logic [2:0]  data_type;
  logic [31:0] cache_written_data;
  logic [1:0]  cache_vis_signal;
  logic        flush_req;
  logic        cache_hit;
  logic [31:0] data;
  logic [1:0]  d_cache_vis_status;
  logic        misaligned;
  logic        flush_done;
  logic [31:0] mem_data = 32'h0;
  logic [1:0]  mem_status = 2'b00;
  logic [1:0]  mem_vis_signal;
  logic [16:0] mem_vis_addr;
  logic [31:0] mem_written_data;

  int          n_checks = 0;
  int          n_errors = 0;
  int          op_count = 0;
  int          mem_cnt = 0;
  logic [1:0]  log_sig  [0:31];
  logic [16:0] log_addr [0:31];
  logic [31:0] log_wd   [0:31];

  write_back_data_cache dut (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_type(data_type),
    .cache_written_data(cache_written_data), .cache_vis_signal(cache_vis_signal),
    .flush_req(flush_req), .cache_hit(cache_hit), .data(data),
    .d_cache_vis_status(d_cache_vis_status), .misaligned(misaligned),
    .flush_done(flush_done), .mem_data(mem_data), .mem_status(mem_status),
    .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
    .mem_written_data(mem_written_data)
  );

  always #5 clk = ~clk;

  // Backing-store contents returned for reads.
  function automatic logic [31:0] rd_val(input logic [16:0] a);
    case (a)
      17'h00100: rd_val = 32'hDEADBEEF;
      17'h00120: rd_val = 32'h12012012;
      17'h00140: rd_val = 32'h14014014;
      default:   rd_val = {15'h0, a};
    endcase
  endfunction

  // Memory responder: completes each request MEM_LAT cycles after it appears and logs it.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_status <= 2'b00;
      mem_cnt    <= 0;
    end else if (mem_status == `MEM_DATA_FINISHED) begin
      mem_status <= 2'b00;
      mem_cnt    <= 0;
    end else if (mem_vis_signal != `MEM_NOP) begin
      if (mem_cnt == MEM_LAT - 1) begin
        mem_status <= `MEM_DATA_FINISHED;
        mem_cnt    <= 0;
        if (mem_vis_signal == `MEM_READ) mem_data <= rd_val(mem_vis_addr);
        log_sig[op_count % 32]  <= mem_vis_signal;
        log_addr[op_count % 32] <= mem_vis_addr;
        log_wd[op_count % 32]   <= mem_written_data;
        op_count <= op_count + 1;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for one clock; returns the combinational hit seen before the edge.
  task automatic access(input logic [1:0] op, input logic [16:0] a, input logic [2:0] t,
                        input logic [31:0] wd, output logic hit);
    cache_vis_signal   = op;
    data_addr          = a;
    data_type          = t;
    cache_written_data = wd;
    #1;
    hit = cache_hit;
    @(posedge clk); #1;
    cache_vis_signal = `D_CACHE_NOP;
  endtask

  task automatic wait_fin(input string tag);
    int n;
    n = 0;
    while (d_cache_vis_status !== `L_S_FINISHED && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {30'h0, d_cache_vis_status}, {30'h0, `L_S_FINISHED});
  endtask

  task automatic do_flush(output int n);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    n = 0;
    while (flush_done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    logic h;
    int   ops0;
    int   n;
    rst_n = 1'b0; data_addr = 17'h0; data_type = `FOUR_BYTE;
    cache_written_data = 32'h0; cache_vis_signal = `D_CACHE_NOP; flush_req = 1'b0;
    #12;
    check("rst_status", {30'h0, d_cache_vis_status}, {30'h0, `D_CACHE_RESTING});
    check("rst_data", data, 32'h0);
    check("rst_memsig", {30'h0, mem_vis_signal}, {30'h0, `MEM_NOP});
    check("rst_memaddr", {15'h0, mem_vis_addr}, 32'h0);
    check("rst_memwd", mem_written_data, 32'h0);
    check("rst_flags", {30'h0, misaligned, flush_done}, 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold load: one read, then the repeat hits with no memory traffic.
    ops0 = op_count;
    access(`D_CACHE_LOAD, 17'h00100, `FOUR_BYTE, 32'h0, h);
    check("cold_hit", {31'h0, h}, 32'h0);
    check("cold_working", {30'h0, d_cache_vis_status}, {30'h0, `D_CACHE_WORKING});
    check("cold_rd_sig", {30'h0, mem_vis_signal}, {30'h0, `MEM_READ});
    check("cold_rd_addr", {15'h0, mem_vis_addr}, 32'h00100);
    @(posedge clk); #1;
    check("cold_stall", {30'h0, d_cache_vis_status}, {30'h0, `D_CACHE_STALL});
    wait_fin("cold_fin");
    check("cold_data", data, 32'hDEADBEEF);
    check("cold_ops", op_count - ops0, 32'd1);
    check("cold_memnop", {30'h0, mem_vis_signal}, {30'h0, `MEM_NOP});
    ops0 = op_count;
    access(`D_CACHE_LOAD, 17'h00100, `FOUR_BYTE, 32'h0, h);
    check("rep_hit", {31'h0, h}, 32'h1);
    check("rep_fin", {30'h0, d_cache_vis_status}, {30'h0, `L_S_FINISHED});
    check("rep_data", data, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("idle_resting", {30'h0, d_cache_vis_status}, {30'h0, `D_CACHE_RESTING});

    // Byte store hit merges one lane; sub-word loads zero-extend.
    access(`D_CACHE_STORE, 17'h00101, `ONE_BYTE, 32'h000000AA, h);
    check("st_hit", {31'h0, h}, 32'h1);
    check("st_fin", {30'h0, d_cache_vis_status}, {30'h0, `L_S_FINISHED});
    access(`D_CACHE_LOAD, 17'h00100, `FOUR_BYTE, 32'h0, h);
    check("st_merged", data, 32'hDEADAAEF);
    access(`D_CACHE_LOAD, 17'h00103, `ONE_BYTE, 32'h0, h);
    check("ld_byte3", data, 32'h000000DE);
    access(`D_CACHE_LOAD, 17'h00102, `TWO_BYTE, 32'h0, h);
    check("ld_half_hi", data, 32'h0000DEAD);
    check("hit_no_ops", op_count - ops0, 32'd0);

    // Misaligned halfword is rejected for exactly one cycle.
    access(`D_CACHE_LOAD, 17'h00103, `TWO_BYTE, 32'h0, h);
    check("mis_pulse", {31'h0, misaligned}, 32'h1);
    check("mis_fin", {30'h0, d_cache_vis_status}, {30'h0, `L_S_FINISHED});
    check("mis_memnop", {30'h0, mem_vis_signal}, {30'h0, `MEM_NOP});
    check("mis_data_kept", data, 32'h0000DEAD);
    @(posedge clk); #1;
    check("mis_drop", {31'h0, misaligned}, 32'h0);

    // Fill the second way, then evict the dirty LRU line.
    access(`D_CACHE_LOAD, 17'h00120, `FOUR_BYTE, 32'h0, h);
    wait_fin("w1_fin");
    check("w1_data", data, 32'h12012012);
    ops0 = op_count;
    access(`D_CACHE_LOAD, 17'h00140, `FOUR_BYTE, 32'h0, h);
    check("ev_hit", {31'h0, h}, 32'h0);
    check("ev_wr_sig", {30'h0, mem_vis_signal}, {30'h0, `MEM_WRITE});
    wait_fin("ev_fin");
    check("ev_ops", op_count - ops0, 32'd2);
    check("ev_op0_sig", {30'h0, log_sig[ops0 % 32]}, {30'h0, `MEM_WRITE});
    check("ev_op0_addr", {15'h0, log_addr[ops0 % 32]}, 32'h00100);
    check("ev_op0_wd", log_wd[ops0 % 32], 32'hDEADAAEF);
    check("ev_op1_sig", {30'h0, log_sig[(ops0 + 1) % 32]}, {30'h0, `MEM_READ});
    check("ev_op1_addr", {15'h0, log_addr[(ops0 + 1) % 32]}, 32'h00140);
    check("ev_data", data, 32'h14014014);
    access(`D_CACHE_LOAD, 17'h00120, `FOUR_BYTE, 32'h0, h);
    check("w1_still_hit", {31'h0, h}, 32'h1);
    check("w1_still_data", data, 32'h12012012);

    // Two dirty lines: one by store hit, one by store miss into set 1.
    access(`D_CACHE_STORE, 17'h00140, `FOUR_BYTE, 32'hCAFEF00D, h);
    check("sd_hit", {31'h0, h}, 32'h1);
    access(`D_CACHE_STORE, 17'h00206, `TWO_BYTE, 32'h0000BEEF, h);
    check("sm_hit", {31'h0, h}, 32'h0);
    wait_fin("sm_fin");
    ops0 = op_count;
    do_flush(n);
    check("fl_done", {31'h0, flush_done}, 32'h1);
    check("fl_ops", op_count - ops0, 32'd2);
    check("fl_op0_addr", {15'h0, log_addr[ops0 % 32]}, 32'h00140);
    check("fl_op0_wd", log_wd[ops0 % 32], 32'hCAFEF00D);
    check("fl_op1_sig", {30'h0, log_sig[(ops0 + 1) % 32]}, {30'h0, `MEM_WRITE});
    check("fl_op1_addr", {15'h0, log_addr[(ops0 + 1) % 32]}, 32'h00204);
    check("fl_op1_wd", log_wd[(ops0 + 1) % 32], 32'hBEEF0204);
    @(posedge clk); #1;
    check("fl_done_drop", {31'h0, flush_done}, 32'h0);

    // Clean flush: one cycle per line, no memory traffic.
    ops0 = op_count;
    do_flush(n);
    check("fl2_cycles", n, 32'd16);
    check("fl2_ops", op_count - ops0, 32'd0);
    access(`D_CACHE_LOAD, 17'h00140, `FOUR_BYTE, 32'h0, h);
    check("fl_kept_hit", {31'h0, h}, 32'h1);
    check("fl_kept_data", data, 32'hCAFEF00D);

    // Reset in the middle of a fill aborts it and invalidates the cache.
    access(`D_CACHE_LOAD, 17'h00300, `FOUR_BYTE, 32'h0, h);
    @(posedge clk); #1;
    check("rf_stall", {30'h0, d_cache_vis_status}, {30'h0, `D_CACHE_STALL});
    check("rf_rd_sig", {30'h0, mem_vis_signal}, {30'h0, `MEM_READ});
    #2 rst_n = 1'b0;
    #1;
    check("rf_memnop", {30'h0, mem_vis_signal}, {30'h0, `MEM_NOP});
    check("rf_resting", {30'h0, d_cache_vis_status}, {30'h0, `D_CACHE_RESTING});
    check("rf_data0", data, 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    access(`D_CACHE_LOAD, 17'h00100, `FOUR_BYTE, 32'h0, h);
    check("rf_miss", {31'h0, h}, 32'h0);
    wait_fin("rf_fin");
    check("rf_data", data, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/write_back_data_cache.md
WRITE_BACK_DATA_CACHE -- requirements
Module: write_back_data_cache

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, byte-address width.
REQ-002 Parameter LEN, default 32, data/line width; one line = one 4-byte word.
REQ-003 Parameter SET_INDEX_SIZE, default 3, log2 of set count (SETS = 1<<SET_INDEX_SIZE); ways fixed at 2; TAG = ADDR_WIDTH-SET_INDEX_SIZE-2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data_addr  input  ADDR_WIDTH  byte address of request.
REQ-007 data_type  input  3  `ONE_BYTE / `TWO_BYTE / `FOUR_BYTE access size.
REQ-008 cache_written_data  input  LEN  store data, right-aligned, little-endian.
REQ-009 cache_vis_signal  input  2  `D_CACHE_NOP / `D_CACHE_LOAD / `D_CACHE_STORE.
REQ-010 flush_req  input  1  write back all dirty lines.
REQ-011 cache_hit  output  1  combinational: request in IDLE hits a valid way.
REQ-012 data  output  LEN  load result, zero-extended, little-endian.
REQ-013 d_cache_vis_status  output  2  `D_CACHE_RESTING / `D_CACHE_WORKING / `D_CACHE_STALL / `L_S_FINISHED.
REQ-014 misaligned  output  1  one-cycle pulse: request rejected as misaligned.
REQ-015 flush_done  output  1  one-cycle pulse: flush complete.
REQ-016 mem_data  input  LEN  memory read word, little-endian.
REQ-017 mem_status  input  2  `MEM_DATA_FINISHED marks completion of current memory op.
REQ-018 mem_vis_signal  output  2  `MEM_NOP / `MEM_READ / `MEM_WRITE, held until completion.
REQ-019 mem_vis_addr  output  ADDR_WIDTH  word-aligned line address (low 2 bits 0).
REQ-020 mem_written_data  output  LEN  full victim line for `MEM_WRITE.

Function
REQ-021 Storage SHALL be 2-way set-associative: per set/way valid, dirty, tag, line; one LRU bit per set naming the least-recently-used way.
REQ-022 States SHALL be IDLE, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB.
REQ-023 In IDLE, LOAD/STORE SHALL be accepted every cycle; addr, type, store data registered on acceptance.
REQ-024 TWO_BYTE with addr[0]=1 or FOUR_BYTE with addr[1:0]!=0 SHALL pulse misaligned, status `L_S_FINISHED, no state/memory change.
REQ-025 Load hit: data updated and status `L_S_FINISHED at the accepting edge (1-cycle latency); LRU set to other way.
REQ-026 Store hit: byte lanes (offset addr[1:0], size data_type) merged into line, dirty set, LRU updated, `L_S_FINISHED at accepting edge; no memory traffic.
REQ-027 Miss victim: first invalid way (way 0 before way 1), else LRU way.
REQ-028 Miss with dirty victim: WRITEBACK issues `MEM_WRITE at {victim tag, index, 00} with victim line, then FILL; clean victim goes directly to FILL.
REQ-029 FILL issues `MEM_READ at {addr[ADDR_WIDTH-1:2],00}; on `MEM_DATA_FINISHED install line (valid=1, dirty=0), then complete load (data) or store (merge, dirty=1), update LRU, `L_S_FINISHED, return to IDLE, mem_vis_signal `MEM_NOP.
REQ-030 While waiting for memory, status SHALL be `D_CACHE_STALL; first cycle of any miss `D_CACHE_WORKING.
REQ-031 IDLE with no request and no flush SHALL drive `D_CACHE_RESTING, `MEM_NOP.
REQ-032 flush_req in IDLE SHALL take priority over a simultaneous request (request ignored, must be re-presented).
REQ-033 Flush SHALL visit set 0..SETS-1, way 0 then 1; each valid dirty line written back (FLUSH_WB) and dirty cleared, valid/LRU kept; clean lines cost one cycle.
REQ-034 flush_done SHALL pulse on the edge returning to IDLE; flush with no dirty lines takes 2*SETS cycles.
REQ-035 Inputs other than mem_data/mem_status SHALL be ignored outside IDLE.

Reset
REQ-036 rst_n low SHALL immediately clear all valid, dirty, LRU bits and force IDLE, data=0, status `D_CACHE_RESTING, mem_vis_signal `MEM_NOP, mem_vis_addr=0, mem_written_data=0, misaligned=0, flush_done=0.
REQ-037 Reset during WRITEBACK/FILL/flush SHALL abort the operation; dirty data is lost; no completion reported.

Verification
REQ-038 Load FOUR_BYTE 0x00100 cold -> one `MEM_READ 0x00100, mem_data 0xDEADBEEF -> data 0xDEADBEEF; repeat -> hit, 1 cycle, no memory op.
REQ-039 Store ONE_BYTE 0xAA at 0x00101 after fill -> hit, no memory op; load FOUR_BYTE 0x00100 -> 0xDEADAAEF.
REQ-040 Fill 0x00100, 0x00120, 0x00140 (same set, SET_INDEX_SIZE=3) with 0x00100 dirty -> `MEM_WRITE 0x00100 then `MEM_READ 0x00140; 0x00120 still hits.
REQ-041 Load TWO_BYTE 0x00103 -> misaligned pulse, `L_S_FINISHED, mem_vis_signal stays `MEM_NOP.
REQ-042 Two dirty lines, flush_req -> exactly two `MEM_WRITE, flush_done pulse, second flush issues no memory op.
REQ-043 rst_n low during FILL stall -> `MEM_NOP immediately; subsequent load to same address misses.
